// File: rtl/ex_stage_pkg.sv
// Shared defines for the execute stage: result-class and operation encodings,
// common constants, divider FSM states and a magnitude helper.
package ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [2:0] ALUSEL_NOP   = 3'b000;
    localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
    localparam logic [2:0] ALUSEL_ARITH = 3'b100;
    localparam logic [2:0] ALUSEL_DIV   = 3'b101;

    localparam logic [7:0] ALUOP_AND  = 8'b0010_0100;
    localparam logic [7:0] ALUOP_OR   = 8'b0010_0101;
    localparam logic [7:0] ALUOP_XOR  = 8'b0010_0110;
    localparam logic [7:0] ALUOP_NOR  = 8'b0010_0111;
    localparam logic [7:0] ALUOP_SLL  = 8'b0111_1100;
    localparam logic [7:0] ALUOP_SRL  = 8'b0000_0010;
    localparam logic [7:0] ALUOP_SRA  = 8'b0000_0011;
    localparam logic [7:0] ALUOP_SLT  = 8'b0010_1010;
    localparam logic [7:0] ALUOP_SLTU = 8'b0010_1011;
    localparam logic [7:0] ALUOP_ADDU = 8'b0010_0001;
    localparam logic [7:0] ALUOP_SUBU = 8'b0010_0011;
    localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
    localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

    localparam logic [DATA_W-1:0] ZERO_WORD     = '0;
    localparam logic [ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic              RST_ENABLE    = 1'b1;
    localparam logic              WRITE_ENABLE  = 1'b1;
    localparam logic              WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Magnitude of a two's-complement word when is_signed, otherwise unchanged.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                   input logic is_signed);
        return (is_signed && x[DATA_W-1]) ? (ZERO_WORD - x) : x;
    endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative 32-step restoring divider (IDLE/BUSY/DONE); present only when
// EX_DIV_EN is defined. Quotient/remainder are driven only in DONE.
`ifdef EX_DIV_EN
module div_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [32:0] shifted, trial;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        shifted   = {rem_q, quo_q[31]};
        trial     = shifted - {1'b0, dvsr_q};

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    if (divisor == ZERO_WORD) begin
                        // Divide by zero skips BUSY and reports the raw dividend.
                        state_d   = DIV_DONE;
                        quo_d     = '1;
                        rem_d     = dividend;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else begin
                        state_d   = DIV_BUSY;
                        cnt_d     = '0;
                        rem_d     = ZERO_WORD;
                        quo_d     = abs_val(dividend, signed_op);
                        dvsr_d    = abs_val(divisor, signed_op);
                        neg_quo_d = signed_op & (dividend[31] ^ divisor[31]);
                        neg_rem_d = signed_op & dividend[31];
                    end
                end
            end
            DIV_BUSY: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = DIV_DONE;
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase

        if (cancel) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: datapath flops carry no reset; they are loaded on start and only observed in DONE.
    always_ff @(posedge clk) begin
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        dvsr_q    <= dvsr_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

    assign busy      = (state_q == DIV_BUSY);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = done ? (neg_quo_q ? (ZERO_WORD - quo_q) : quo_q) : ZERO_WORD;
    assign remainder = done ? (neg_rem_q ? (ZERO_WORD - rem_q) : rem_q) : ZERO_WORD;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: combinational logic/shift/arith ALU plus stall and HI/LO
// control; the iterative divider is built in only when EX_DIV_EN is defined.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [2:0]  alusel_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  waddr_i,
    input  logic        reg_we_i,
    output logic [4:0]  waddr_o,
    output logic        reg_we_o,
    output logic [31:0] wdata_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    logic        div_class;
    logic [31:0] alu_result;
    logic        stall_raw, hilo_we_raw;
    logic [31:0] hi_raw, lo_raw;

    assign div_class = (alusel_i == ALUSEL_DIV);

    always_comb begin
        alu_result = ZERO_WORD;
        case (alusel_i)
            ALUSEL_LOGIC: begin
                case (aluop_i)
                    ALUOP_OR:  alu_result = reg1_i | reg2_i;
                    ALUOP_AND: alu_result = reg1_i & reg2_i;
                    ALUOP_XOR: alu_result = reg1_i ^ reg2_i;
                    ALUOP_NOR: alu_result = ~(reg1_i | reg2_i);
                    default:   alu_result = ZERO_WORD;
                endcase
            end
            ALUSEL_SHIFT: begin
                case (aluop_i)
                    ALUOP_SLL: alu_result = reg1_i << reg2_i[4:0];
                    ALUOP_SRL: alu_result = reg1_i >> reg2_i[4:0];
                    ALUOP_SRA: alu_result = $signed(reg1_i) >>> reg2_i[4:0];
                    default:   alu_result = ZERO_WORD;
                endcase
            end
            ALUSEL_ARITH: begin
                case (aluop_i)
                    ALUOP_ADDU: alu_result = reg1_i + reg2_i;
                    ALUOP_SUBU: alu_result = reg1_i - reg2_i;
                    ALUOP_SLT:  alu_result = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
                    ALUOP_SLTU: alu_result = {31'b0, reg1_i < reg2_i};
                    default:    alu_result = ZERO_WORD;
                endcase
            end
            default: alu_result = ZERO_WORD;
        endcase
    end

`ifdef EX_DIV_EN
    logic        div_done, unused_div_busy;
    logic [31:0] div_quo, div_rem;

    div_unit u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_class && !flush),
        .signed_op (aluop_i == ALUOP_DIV),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .cancel    (flush),
        .busy      (unused_div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // In DONE the stall drops so ID/EX advances and the held DIV is not restarted.
    assign stall_raw   = div_class && !div_done && !flush;
    assign hilo_we_raw = div_done && !flush;
    assign hi_raw      = flush ? ZERO_WORD : div_rem;
    assign lo_raw      = flush ? ZERO_WORD : div_quo;
`else
    logic unused_no_div;
    assign unused_no_div = ^{clk, flush};
    assign stall_raw     = 1'b0;
    assign hilo_we_raw   = 1'b0;
    assign hi_raw        = ZERO_WORD;
    assign lo_raw        = ZERO_WORD;
`endif

    always_comb begin
        waddr_o    = NOP_REG_ADDR;
        reg_we_o   = WRITE_DISABLE;
        wdata_o    = ZERO_WORD;
        hilo_we_o  = 1'b0;
        hi_o       = ZERO_WORD;
        lo_o       = ZERO_WORD;
        stallreq_o = 1'b0;
        if (rst != RST_ENABLE) begin
            waddr_o    = waddr_i;
            reg_we_o   = div_class ? WRITE_DISABLE : reg_we_i;
            wdata_o    = alu_result;
            hilo_we_o  = hilo_we_raw;
            hi_o       = hi_raw;
            lo_o       = lo_raw;
            stallreq_o = stall_raw;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table-driven ALU vectors plus divider
// sequences (timing, divide-by-zero, overflow, flush, reset) when EX_DIV_EN is set.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [2:0]  alusel;
    logic [7:0]  aluop;
    logic [31:0] reg1, reg2;
    logic [4:0]  waddr;
    logic        reg_we;
    logic [4:0]  waddr_o;
    logic        reg_we_o, hilo_we_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    int n_checks = 0;
    int n_pass   = 0;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .alusel_i   (alusel),
        .aluop_i    (aluop),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .waddr_i    (waddr),
        .reg_we_i   (reg_we),
        .waddr_o    (waddr_o),
        .reg_we_o   (reg_we_o),
        .wdata_o    (wdata_o),
        .hilo_we_o  (hilo_we_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic drive(input logic [2:0] s, input logic [7:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa, input logic we);
        alusel = s; aluop = o; reg1 = a; reg2 = b; waddr = wa; reg_we = we;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " stallreq"}, 32'(stallreq_o), 32'd0);
        check({name, " hilo_we"},  32'(hilo_we_o),  32'd0);
        check({name, " hi"},       hi_o,            32'd0);
        check({name, " lo"},       lo_o,            32'd0);
        check({name, " wdata"},    wdata_o,         32'd0);
        check({name, " reg_we"},   32'(reg_we_o),   32'd0);
        check({name, " waddr"},    32'(waddr_o),    32'd0);
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wa;
        logic        we;
        logic [31:0] exp_wdata;
        logic        exp_we;
    } vec_t;

    vec_t vecs[13];

`ifdef EX_DIV_EN
    // Issues one divide, counts stall cycles, then checks the DONE-cycle results
    // and that everything is quiet once the pipeline moves on.
    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int   n;
        logic early;
        @(posedge clk); #2;
        drive(ALUSEL_DIV, op, a, b, 5'd9, 1'b1);
        #1;
        n = 0;
        early = 1'b0;
        while (stallreq_o === 1'b1 && n < 40) begin
            if (hilo_we_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) early = 1'b1;
            @(posedge clk); #3;
            n++;
        end
        check({name, " stall cycles"}, 32'(n), 32'(exp_stall));
        check({name, " quiet while busy"}, 32'(early), 32'd0);
        check({name, " hilo_we"}, 32'(hilo_we_o), 32'd1);
        check({name, " lo"}, lo_o, exp_lo);
        check({name, " hi"}, hi_o, exp_hi);
        check({name, " reg_we"}, 32'(reg_we_o), 32'd0);
        @(posedge clk); #2;
        drive(ALUSEL_NOP, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        check({name, " after hilo_we"}, 32'(hilo_we_o), 32'd0);
        check({name, " after lo"}, lo_o, 32'd0);
        check({name, " after stall"}, 32'(stallreq_o), 32'd0);
    endtask
`endif

    initial begin
        vecs[0]  = '{ALUSEL_LOGIC, ALUOP_OR,   32'h0F0F_00FF, 32'hFFFF_0000, 5'd1,  1'b1, 32'hFFFF_00FF, 1'b1};
        vecs[1]  = '{ALUSEL_LOGIC, ALUOP_AND,  32'h0F0F_00FF, 32'hFFFF_0000, 5'd2,  1'b1, 32'h0F0F_0000, 1'b1};
        vecs[2]  = '{ALUSEL_LOGIC, ALUOP_XOR,  32'h0F0F_00FF, 32'hFFFF_0000, 5'd3,  1'b0, 32'hF0F0_00FF, 1'b0};
        vecs[3]  = '{ALUSEL_LOGIC, ALUOP_NOR,  32'h0F0F_00FF, 32'hFFFF_0000, 5'd4,  1'b1, 32'h0000_FF00, 1'b1};
        vecs[4]  = '{ALUSEL_SHIFT, ALUOP_SRA,  32'h8000_0000, 32'd4,         5'd5,  1'b1, 32'hF800_0000, 1'b1};
        vecs[5]  = '{ALUSEL_SHIFT, ALUOP_SRL,  32'h8000_0000, 32'd4,         5'd6,  1'b1, 32'h0800_0000, 1'b1};
        vecs[6]  = '{ALUSEL_SHIFT, ALUOP_SLL,  32'h0000_000F, 32'hFFFF_FFFC, 5'd7,  1'b1, 32'hF000_0000, 1'b1};
        vecs[7]  = '{ALUSEL_ARITH, ALUOP_SLT,  32'hFFFF_FFFF, 32'd1,         5'd8,  1'b1, 32'd1,         1'b1};
        vecs[8]  = '{ALUSEL_ARITH, ALUOP_SLTU, 32'hFFFF_FFFF, 32'd1,         5'd9,  1'b1, 32'd0,         1'b1};
        vecs[9]  = '{ALUSEL_ARITH, ALUOP_ADDU, 32'hFFFF_FFFF, 32'd2,         5'd10, 1'b1, 32'd1,         1'b1};
        vecs[10] = '{ALUSEL_ARITH, ALUOP_SUBU, 32'd0,         32'd1,         5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[11] = '{ALUSEL_NOP,   ALUOP_OR,   32'h1234_5678, 32'h0000_FFFF, 5'd12, 1'b1, 32'd0,         1'b1};
        vecs[12] = '{ALUSEL_LOGIC, 8'hFF,      32'h1234_5678, 32'h0000_FFFF, 5'd13, 1'b1, 32'd0,         1'b1};

        // Reset forces every output low even with a live instruction on the input.
        rst = 1'b1;
        flush = 1'b0;
        drive(ALUSEL_LOGIC, ALUOP_OR, 32'hAAAA_5555, 32'h1, 5'd7, 1'b1);
        @(posedge clk); #2;
        @(posedge clk); #3;
        check_all_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk); #2;
            drive(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wa, vecs[i].we);
            #1;
            check($sformatf("vec%0d wdata", i), wdata_o, vecs[i].exp_wdata);
            check($sformatf("vec%0d reg_we", i), 32'(reg_we_o), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d waddr", i), 32'(waddr_o), 32'(vecs[i].wa));
            check($sformatf("vec%0d stall", i), 32'(stallreq_o), 32'd0);
        end

`ifdef EX_DIV_EN
        run_div("div -7/2",     ALUOP_DIV,  32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("divu 100/0",   ALUOP_DIVU, 32'd100,       32'd0,         1,  32'hFFFF_FFFF, 32'd100);
        run_div("div -7/0",     ALUOP_DIV,  32'hFFFF_FFF9, 32'd0,         1,  32'hFFFF_FFFF, 32'hFFFF_FFF9);
        run_div("div overflow", ALUOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);

        // Flush in the 10th cycle of a DIVU abandons it with no HI/LO write.
        begin
            logic bad;
            @(posedge clk); #2;
            drive(ALUSEL_DIV, ALUOP_DIVU, 32'hFFFF_FFFF, 32'd3, 5'd9, 1'b1);
            #1;
            for (int c = 1; c < 10; c++) begin
                @(posedge clk); #3;
            end
            check("flush pre stall", 32'(stallreq_o), 32'd1);
            flush = 1'b1;
            #1;
            check("flush stall", 32'(stallreq_o), 32'd0);
            check("flush hilo_we", 32'(hilo_we_o), 32'd0);
            @(posedge clk); #2;
            flush = 1'b0;
            drive(ALUSEL_NOP, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0);
            bad = 1'b0;
            for (int c = 0; c < 40; c++) begin
                #1;
                if (hilo_we_o !== 1'b0 || stallreq_o !== 1'b0) bad = 1'b1;
                @(posedge clk); #2;
            end
            check("flush no later hilo_we", 32'(bad), 32'd0);
        end
        run_div("div 100/-7 after flush", ALUOP_DIV, 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 32'd2);

        // Reset in the 20th cycle of a divide, then a fresh divide must take full latency.
        @(posedge clk); #2;
        drive(ALUSEL_DIV, ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1);
        #1;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #3;
        end
        check("mid-div stall", 32'(stallreq_o), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("rst mid-div");
        @(posedge clk); #3;
        check_all_zero("rst held");
        @(posedge clk); #2;
        rst = 1'b0;
        run_div("div overflow after rst", ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
`else
        // Without the divider a DIV op behaves as a bubble.
        @(posedge clk); #2;
        drive(ALUSEL_DIV, ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("nodiv stall c%0d", c), 32'(stallreq_o), 32'd0);
            check($sformatf("nodiv hilo_we c%0d", c), 32'(hilo_we_o), 32'd0);
            check($sformatf("nodiv wdata c%0d", c), wdata_o, 32'd0);
            check($sformatf("nodiv hi c%0d", c), hi_o, 32'd0);
            check($sformatf("nodiv lo c%0d", c), lo_o, 32'd0);
            @(posedge clk); #2;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
